// File: rtl/countdown_timer.sv
// MM:SS countdown timer with BCD display, pause/resume and alarm.
// Counts down from preset minutes at one decrement per TICKS_PER_SEC clocks.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  set_time,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mm_q, mm_d;
  logic [7:0]    ss_q, ss_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic [7:0]    preset;
  logic [15:0]   dec;
  logic          tick;

  // Limit each preset nibble to a legal BCD digit.
  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // One-second BCD decrement of MM:SS with borrow chain.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    logic       b;
    {mt, mu, st, su} = t;
    b = (su == 4'd0);
    su = b ? 4'd9 : su - 4'd1;
    if (b) begin
      b = (st == 4'd0);
      st = b ? 4'd5 : st - 4'd1;
    end
    if (b) begin
      b = (mu == 4'd0);
      mu = b ? 4'd9 : mu - 4'd1;
    end
    if (b) mt = mt - 4'd1;
    return {mt, mu, st, su};
  endfunction

  assign preset = {clamp9(set_time[7:4]), clamp9(set_time[3:0])};
  assign tick   = (state_q == RUN) && (presc_q == TERM);
  assign dec    = bcd_dec({mm_q, ss_q});

  // Next-state, counter and display update logic.
  always_comb begin
    state_d = state_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      mm_d    = preset;
      ss_d    = 8'h00;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start && preset != 8'h00) begin
            state_d = RUN;
            mm_d    = preset;
            ss_d    = 8'h00;
            presc_d = '0;
          end else if (state_q == IDLE) begin
            mm_d = preset;
            ss_d = 8'h00;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            presc_d      = '0;
            {mm_d, ss_d} = dec;
            if (dec == 16'h0000) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSED: begin
          if (start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign digits  = {mm_q, ss_q};
  assign running = (state_q == RUN);
  assign alarm   = (state_q == DONE);
  assign done    = done_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter: TICKS_PER_SEC, default 50000000, number of clk cycles per one-second decrement (minimum 2).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: set_time  input  8  preset minutes from the adder stage, BCD; [3:0] minutes units, [7:4] minutes tens.
REQ-005 SHALL have port: start  input  1  one-cycle pulse; start from IDLE/DONE, resume from PAUSED.
REQ-006 SHALL have port: pause  input  1  one-cycle pulse; suspend counting while running.
REQ-007 SHALL have port: clear  input  1  one-cycle pulse; abort to IDLE.
REQ-008 SHALL have port: digits  output  16  displayed time, BCD; [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
REQ-009 SHALL have port: running  output  1  high while in RUN.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on reaching 00:00.
REQ-011 SHALL have port: alarm  output  1  level, high in DONE.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSED, DONE; encoding free.
REQ-013 SHALL clamp each set_time nibble >9 to 9 before use (display and load).
REQ-014 IDLE SHALL display clamped set_time as minutes and 00 seconds, tracking set_time combinationally through the registered minutes load each cycle (1-cycle latency).
REQ-015 start in IDLE with clamped set_time nonzero SHALL load MM=set_time, SS=00, clear prescaler, enter RUN next cycle; start with set_time==00 SHALL be ignored.
REQ-016 Prescaler SHALL count 0..TICKS_PER_SEC-1 only in RUN, issuing an internal tick on the terminal count and wrapping to 0.
REQ-017 Each tick SHALL decrement MM:SS by one second in BCD: sec units 0->9 with borrow, sec tens 0->5 with borrow, min units 0->9 with borrow, min tens decrement; no non-BCD value ever displayed.
REQ-018 First decrement SHALL occur exactly TICKS_PER_SEC cycles after the cycle RUN is entered.
REQ-019 Tick producing 00:00 SHALL enter DONE the same edge; done high for exactly that following cycle; alarm high from then until leaving DONE.
REQ-020 pause in RUN SHALL enter PAUSED, freezing digits and prescaler value; pause in other states ignored.
REQ-021 start in PAUSED SHALL return to RUN without reload; prescaler continues from frozen value.
REQ-022 start in RUN SHALL be ignored; start in DONE SHALL behave as start in IDLE (reload, alarm low).
REQ-023 clear in any state SHALL enter IDLE next cycle, alarm low, prescaler zero.
REQ-024 Simultaneous pulses SHALL resolve clear > start > pause.
REQ-025 Tick coinciding with pause or clear SHALL be discarded (no decrement).
REQ-026 DONE SHALL display 00:00 and hold until start or clear.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, digits=16'h0000, prescaler 0, running=0, done=0, alarm=0, including mid-RUN.
REQ-028 After rst_n release, first state change SHALL occur no earlier than the next rising clk edge.

Verification (TICKS_PER_SEC=4)
REQ-029 Reset mid-RUN at 00:42 -> outputs zero asynchronously, before next edge; IDLE thereafter.
REQ-030 set_time=8'h01, start -> digits 16'h0100, 00:59 after 4 cycles, 00:00 after 240 cycles; done high one cycle; alarm held; running=0.
REQ-031 set_time=8'h10, start, 4 cycles -> digits 16'h0959 (full borrow chain).
REQ-032 pause at 00:57 with prescaler=2, hold 20 cycles, start -> digits unchanged during pause; 00:56 exactly 2 cycles after resume.
REQ-033 clear and start same cycle in RUN -> IDLE, running=0, no reload; start+pause in PAUSED -> resumes RUN.
REQ-034 set_time=8'h00, start -> stays IDLE; set_time=8'hFA, start -> digits 16'h9900.
